// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared definitions for the unified-memory bus arbiter: default bus widths
//   (address, data, byte-select) and the 2-bit FSM state encodings.
//   States are plain localparam constants so that older code that compares
//   raw 2-bit state values keeps working.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    // Default widths of the core's memory-side buses.
    localparam int ARB_ADDR_WIDTH = 32;
    localparam int ARB_DATA_WIDTH = 32;
    localparam int ARB_SEL_WIDTH  = ARB_DATA_WIDTH / 8;

    // Width of the optional performance counters.
    localparam int PERF_CNT_WIDTH = 32;

    // Arbiter FSM encodings.
    localparam logic [1:0] ARB_IDLE   = 2'd0;  // accept new requests, issue first
    localparam logic [1:0] ARB_D_WAIT = 2'd1;  // dbus data returning, ibus may issue
    localparam logic [1:0] ARB_I_WAIT = 2'd2;  // ibus data returning
    localparam logic [1:0] ARB_DONE   = 2'd3;  // release stall, core advances

endpackage

// File: rtl/mem_bus_arbiter_perf.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_perf
//   Pair of free-running event counters for the arbiter. Only instantiated
//   when MEM_BUS_ARBITER_PERF_EN is defined.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset, clears both counters
//   stall             arbiter is holding the core this cycle
//   conflict          both buses requested in the same IDLE cycle
//   perf_stall_cnt    number of stalled cycles (wraps modulo 2^32)
//   perf_conflict_cnt number of conflicting IDLE cycles (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module mem_bus_arbiter_perf
    import mem_bus_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      conflict,
    output logic [PERF_CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [PERF_CNT_WIDTH-1:0] perf_conflict_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (conflict) begin
                perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-ported, synchronous-read memory between the core's
//   instruction port (ibus) and data port (dbus). Simultaneous requests are
//   serialized with dbus first (it belongs to the older instruction); the
//   ibus access is issued in the same transaction, in the cycle the dbus data
//   returns, so ibus is never starved. The core is stalled until every
//   enabled request has completed, and read data is returned from holding
//   registers that stay stable while the core advances.
//
//   Optional feature: define MEM_BUS_ARBITER_PERF_EN to add the
//   perf_stall_cnt / perf_conflict_cnt outputs and their counters.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ibus_en/_write_en/_addr/_write_data   instruction-port request
//   ibus_read_data                 held instruction read data
//   dbus_en/_write_en/_addr/_write_data   data-port request
//   dbus_read_data                 held data read data
//   mem_en/_write_en/_addr/_write_data    memory request (combinational)
//   mem_read_data                  memory read data, valid the cycle after issue
//   stall                          hold request to the core
//   perf_stall_cnt, perf_conflict_cnt     (MEM_BUS_ARBITER_PERF_EN only)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int SEL_WIDTH  = ARB_SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ibus_en,
    input  logic [SEL_WIDTH-1:0]  ibus_write_en,
    input  logic [ADDR_WIDTH-1:0] ibus_addr,
    input  logic [DATA_WIDTH-1:0] ibus_write_data,
    output logic [DATA_WIDTH-1:0] ibus_read_data,

    input  logic                  dbus_en,
    input  logic [SEL_WIDTH-1:0]  dbus_write_en,
    input  logic [ADDR_WIDTH-1:0] dbus_addr,
    input  logic [DATA_WIDTH-1:0] dbus_write_data,
    output logic [DATA_WIDTH-1:0] dbus_read_data,

    output logic                  mem_en,
    output logic [SEL_WIDTH-1:0]  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,

    output logic                  stall
`ifdef MEM_BUS_ARBITER_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [PERF_CNT_WIDTH-1:0] perf_conflict_cnt
`endif
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       issue_d;     // dbus request goes to memory this cycle
    logic       issue_i;     // ibus request goes to memory this cycle
    logic       stall_raw;   // stall before reset gating

    // -------------------------------------------------------------------------
    // Next-state, issue and stall decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        issue_d    = 1'b0;
        issue_i    = 1'b0;
        stall_raw  = 1'b0;

        case (state)
            ARB_IDLE: begin
                stall_raw = ibus_en | dbus_en;
                if (dbus_en) begin
                    issue_d    = 1'b1;
                    state_next = ARB_D_WAIT;
                end else if (ibus_en) begin
                    issue_i    = 1'b1;
                    state_next = ARB_I_WAIT;
                end
            end
            ARB_D_WAIT: begin
                // The memory port is free again while dbus data returns, so
                // a pending fetch is issued back-to-back.
                stall_raw = 1'b1;
                if (ibus_en) begin
                    issue_i    = 1'b1;
                    state_next = ARB_I_WAIT;
                end else begin
                    state_next = ARB_DONE;
                end
            end
            ARB_I_WAIT: begin
                stall_raw  = 1'b1;
                state_next = ARB_DONE;
            end
            ARB_DONE: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Reset must silence the core interface immediately, not one edge later.
    assign mem_en = ~rst & (issue_d | issue_i);
    assign stall  = ~rst & stall_raw;

    // -------------------------------------------------------------------------
    // Memory request mux: all request fields are zero while no access is made
    // -------------------------------------------------------------------------
    always_comb begin
        mem_write_en   = '0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (mem_en) begin
            if (issue_d) begin
                mem_write_en   = dbus_write_en;
                mem_addr       = dbus_addr;
                mem_write_data = dbus_write_data;
            end else begin
                mem_write_en   = ibus_write_en;
                mem_addr       = ibus_addr;
                mem_write_data = ibus_write_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and read-data holding registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the holding registers are individual flops visible to the
            // core, so they are reset; an interrupted transaction is dropped.
            state          <= ARB_IDLE;
            ibus_read_data <= '0;
            dbus_read_data <= '0;
        end else begin
            state <= state_next;
            // Capture only reads; a write leaves the previous value in place.
            if (state == ARB_D_WAIT && dbus_write_en == '0) begin
                dbus_read_data <= mem_read_data;
            end
            if (state == ARB_I_WAIT && ibus_write_en == '0) begin
                ibus_read_data <= mem_read_data;
            end
        end
    end

`ifdef MEM_BUS_ARBITER_PERF_EN
    logic conflict;
    assign conflict = ~rst & (state == ARB_IDLE) & ibus_en & dbus_en;

    mem_bus_arbiter_perf u_perf (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .conflict          (conflict),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter. Acts as the core (holds requests
//   while stall=1) and as a synchronous-read memory. Expected values come
//   from a transaction-level model: each core step is a set of up to two
//   requests, served dbus before ibus against a reference memory image.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int STALL_BUDGET = 10;

    typedef struct {
        logic        i_en;
        logic [3:0]  i_we;
        logic [31:0] i_addr;
        logic [31:0] i_wd;
        logic        d_en;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wd;
    } req_t;

    typedef struct {
        string       name;
        req_t        req;
        int          exp_stall;
        logic [31:0] exp_i_rd;
        logic [31:0] exp_d_rd;
    } vec_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_en, dbus_en;
    logic [3:0]  ibus_write_en, dbus_write_en;
    logic [31:0] ibus_addr, ibus_write_data, ibus_read_data;
    logic [31:0] dbus_addr, dbus_write_data, dbus_read_data;
    logic        mem_en;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;
    logic        stall;
`ifdef MEM_BUS_ARBITER_PERF_EN
    logic [31:0] perf_stall_cnt, perf_conflict_cnt;
    logic [31:0] snap_stall, snap_conf;
`endif

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .ibus_en         (ibus_en),
        .ibus_write_en   (ibus_write_en),
        .ibus_addr       (ibus_addr),
        .ibus_write_data (ibus_write_data),
        .ibus_read_data  (ibus_read_data),
        .dbus_en         (dbus_en),
        .dbus_write_en   (dbus_write_en),
        .dbus_addr       (dbus_addr),
        .dbus_write_data (dbus_write_data),
        .dbus_read_data  (dbus_read_data),
        .mem_en          (mem_en),
        .mem_write_en    (mem_write_en),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .stall           (stall)
`ifdef MEM_BUS_ARBITER_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    int checks    = 0;
    int failures  = 0;
    int zero_viol = 0;

    logic [31:0] phys_mem [logic [31:0]];  // the memory the DUT talks to
    logic [31:0] ref_mem  [logic [31:0]];  // the model's expected image
    logic [31:0] m_i_rd, m_d_rd;           // model's held read data
    acc_t        acc_q [$];                // accesses seen by the memory

    // ------------------------------------------------------------------ utils
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] def_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_val(a);
    endfunction

    function automatic logic [31:0] phys_read(input logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return def_val(a);
    endfunction

    function automatic req_t mk_req(input logic i_en, input logic [3:0] i_we,
                                    input logic [31:0] i_addr, input logic [31:0] i_wd,
                                    input logic d_en, input logic [3:0] d_we,
                                    input logic [31:0] d_addr, input logic [31:0] d_wd);
        req_t r;
        r.i_en = i_en; r.i_we = i_we; r.i_addr = i_addr; r.i_wd = i_wd;
        r.d_en = d_en; r.d_we = d_we; r.d_addr = d_addr; r.d_wd = d_wd;
        return r;
    endfunction

    function automatic vec_t mk_vec(input string name, input req_t r, input int st,
                                    input logic [31:0] ei, input logic [31:0] ed);
        vec_t v;
        v.name = name; v.req = r; v.exp_stall = st; v.exp_i_rd = ei; v.exp_d_rd = ed;
        return v;
    endfunction

    task automatic drive(input req_t r);
        ibus_en = r.i_en; ibus_write_en = r.i_we; ibus_addr = r.i_addr; ibus_write_data = r.i_wd;
        dbus_en = r.d_en; dbus_write_en = r.d_we; dbus_addr = r.d_addr; dbus_write_data = r.d_wd;
    endtask

    // ---------------------------------------------------------- memory model
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            acc_q.push_back('{we: mem_write_en, addr: mem_addr, wd: mem_write_data});
            mem_read_data <= phys_read(mem_addr);
            if (mem_write_en != 4'h0)
                phys_mem[mem_addr] = merge(phys_read(mem_addr), mem_write_en, mem_write_data);
        end
    end

    // Idle memory request fields must be all zero.
    always begin
        @(negedge clk);
        #2;
        if (mem_en !== 1'b1 && {mem_write_en, mem_addr, mem_write_data} !== 68'h0)
            zero_viol++;
    end

    // ------------------------------------------------------ transaction model
    // One core step: dbus is served before ibus; each access costs one stalled
    // cycle plus one more for the final data return; no request costs nothing.
    task automatic model_txn(input req_t r, output int st);
        if (r.d_en) begin
            if (r.d_we == 4'h0) m_d_rd = ref_read(r.d_addr);
            else ref_mem[r.d_addr] = merge(ref_read(r.d_addr), r.d_we, r.d_wd);
        end
        if (r.i_en) begin
            if (r.i_we == 4'h0) m_i_rd = ref_read(r.i_addr);
            else ref_mem[r.i_addr] = merge(ref_read(r.i_addr), r.i_we, r.i_wd);
        end
        st = int'(r.d_en) + int'(r.i_en) + ((r.d_en || r.i_en) ? 1 : 0);
    endtask

    // Wait for stall to drop (bounded) and check the completed step.
    task automatic finish_txn(input string name, input req_t r, input int exp_stall,
                              input logic [31:0] exp_i, input logic [31:0] exp_d);
        int   cycles;
        acc_t exp_q [$];
        cycles = 0;
        while (stall === 1'b1 && cycles < STALL_BUDGET) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        check({name, ":stall_cycles"}, 64'(cycles), 64'(exp_stall));
        check({name, ":ibus_rd"}, 64'(ibus_read_data), 64'(exp_i));
        check({name, ":dbus_rd"}, 64'(dbus_read_data), 64'(exp_d));
        if (r.d_en) exp_q.push_back('{we: r.d_we, addr: r.d_addr, wd: r.d_wd});
        if (r.i_en) exp_q.push_back('{we: r.i_we, addr: r.i_addr, wd: r.i_wd});
        check({name, ":acc_count"}, 64'(acc_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            check($sformatf("%s:acc%0d_addr", name, k), 64'(acc_q[k].addr), 64'(exp_q[k].addr));
            check($sformatf("%s:acc%0d_we_wd", name, k), {28'h0, acc_q[k].we, acc_q[k].wd},
                  {28'h0, exp_q[k].we, exp_q[k].wd});
        end
`ifdef MEM_BUS_ARBITER_PERF_EN
        check({name, ":perf_stall_delta"}, 64'(perf_stall_cnt - snap_stall), 64'(exp_stall));
        check({name, ":perf_conflict_delta"}, 64'(perf_conflict_cnt - snap_conf),
              64'((r.i_en && r.d_en) ? 1 : 0));
`endif
    endtask

    task automatic run_txn(input string name, input req_t r, input int exp_stall,
                           input logic [31:0] exp_i, input logic [31:0] exp_d);
        @(negedge clk);
        acc_q.delete();
`ifdef MEM_BUS_ARBITER_PERF_EN
        snap_stall = perf_stall_cnt;
        snap_conf  = perf_conflict_cnt;
`endif
        drive(r);
        #1;
        finish_txn(name, r, exp_stall, exp_i, exp_d);
    endtask

    // ------------------------------------------------------------------- test
    vec_t vecs [10];
    req_t idle_req;

    initial begin
        req_t r;
        int   st;

        idle_req = mk_req(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        phys_mem[32'h10]  = 32'h2408_ABCD;  ref_mem[32'h10]  = 32'h2408_ABCD;
        phys_mem[32'h100] = 32'hABCD_0000;  ref_mem[32'h100] = 32'hABCD_0000;

        // Reset held for two cycles with a fetch pending.
        r = mk_req(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        drive(r);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset%0d:stall_mem_en", c), {62'h0, stall, mem_en}, 64'h0);
            check($sformatf("reset%0d:read_data", c), {ibus_read_data, dbus_read_data}, 64'h0);
        end
`ifdef MEM_BUS_ARBITER_PERF_EN
        check("reset:perf_counters", {perf_stall_cnt, perf_conflict_cnt}, 64'h0);
        snap_stall = perf_stall_cnt;
        snap_conf  = perf_conflict_cnt;
`endif
        m_i_rd = 32'h0;
        m_d_rd = 32'h0;
        acc_q.delete();
        rst = 1'b0;
        #1;
        check("reset_release:issue_ibus", {31'h0, mem_en, mem_addr}, {31'h0, 1'b1, 32'h10});
        model_txn(r, st);
        finish_txn("reset_release", r, st, m_i_rd, m_d_rd);

        // Directed table.
        vecs[0] = mk_vec("fetch",      mk_req(1, 4'h0, 32'h10, 0, 0, 4'h0, 0, 0),
                         2, 32'h2408_ABCD, 32'h0);
        vecs[1] = mk_vec("conflict",   mk_req(1, 4'h0, 32'h14, 0, 1, 4'h0, 32'h100, 0),
                         3, 32'h0014_FFEB, 32'hABCD_0000);
        vecs[2] = mk_vec("dwrite",     mk_req(0, 4'h0, 0, 0, 1, 4'b0011, 32'h200, 32'h1234_5678),
                         2, 32'h0014_FFEB, 32'hABCD_0000);
        vecs[3] = mk_vec("dread_back", mk_req(0, 4'h0, 0, 0, 1, 4'h0, 32'h200, 0),
                         2, 32'h0014_FFEB, 32'h0200_5678);
        vecs[4] = mk_vec("no_request", idle_req, 0, 32'h0014_FFEB, 32'h0200_5678);
        vecs[5] = mk_vec("iwrite",     mk_req(1, 4'hF, 32'h300, 32'hCAFE_F00D, 0, 4'h0, 0, 0),
                         2, 32'h0014_FFEB, 32'h0200_5678);
        vecs[6] = mk_vec("iread_back", mk_req(1, 4'h0, 32'h300, 0, 0, 4'h0, 0, 0),
                         2, 32'hCAFE_F00D, 32'h0200_5678);
        vecs[7] = mk_vec("dw_then_ir", mk_req(1, 4'h0, 32'h10, 0, 1, 4'b1100, 32'h10, 32'hBEEF_0000),
                         3, 32'hBEEF_ABCD, 32'h0200_5678);
        vecs[8] = mk_vec("both_writes", mk_req(1, 4'b1000, 32'h14, 32'h2200_0000,
                                               1, 4'b0001, 32'h14, 32'h0000_0011),
                         3, 32'hBEEF_ABCD, 32'h0200_5678);
        vecs[9] = mk_vec("dr_iw",      mk_req(1, 4'b0001, 32'h300, 32'h0000_00AA,
                                               1, 4'h0, 32'h14, 0),
                         3, 32'hBEEF_ABCD, 32'h2214_FF11);
        foreach (vecs[v]) begin
            model_txn(vecs[v].req, st);
            run_txn(vecs[v].name, vecs[v].req, vecs[v].exp_stall, vecs[v].exp_i_rd, vecs[v].exp_d_rd);
        end

        // Core drops dbus_en while stalled: the FSM must still finish the step.
        @(negedge clk);
        r = mk_req(0, 4'h0, 0, 0, 1, 4'h0, 32'h100, 0);
        model_txn(r, st);
        drive(r);
        @(negedge clk);
        #1;
        drive(idle_req);
        $display("note: core drops dbus_en while stalled (contract violation injected)");
        #1;
        check("drop:d_wait_stall_mem_en", {62'h0, stall, mem_en}, 64'h2);
        @(negedge clk);
        #1;
        check("drop:done_stall", {63'h0, stall}, 64'h0);
        check("drop:dbus_rd", 64'(dbus_read_data), 64'(m_d_rd));

        // Reset in D_WAIT: pending ibus issue is suppressed and buffers clear.
        @(negedge clk);
        acc_q.delete();
        drive(mk_req(1, 4'h0, 32'h14, 0, 1, 4'h0, 32'h100, 0));
        @(negedge clk);
        #1;
        check("rst_mid:d_wait_issue_ibus", {31'h0, mem_en, mem_addr}, {31'h0, 1'b1, 32'h14});
        rst = 1'b1;
        #1;
        check("rst_mid:stall_mem_en", {62'h0, stall, mem_en}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(idle_req);
        #1;
        check("rst_mid:read_data", {ibus_read_data, dbus_read_data}, 64'h0);
        check("rst_mid:stall_mem_en_after", {62'h0, stall, mem_en}, 64'h0);
        check("rst_mid:acc_count", 64'(acc_q.size()), 64'h1);
        m_i_rd = 32'h0;
        m_d_rd = 32'h0;
        r = mk_req(1, 4'h0, 32'h14, 0, 0, 4'h0, 0, 0);
        model_txn(r, st);
        run_txn("post_reset_fetch", r, st, m_i_rd, m_d_rd);

        // Ten idle cycles: nothing moves and the holding registers keep data.
        @(negedge clk);
        drive(idle_req);
`ifdef MEM_BUS_ARBITER_PERF_EN
        snap_stall = perf_stall_cnt;
`endif
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle%0d:stall_mem_en", c), {62'h0, stall, mem_en}, 64'h0);
        end
        check("idle:read_data_held", {ibus_read_data, dbus_read_data}, {m_i_rd, m_d_rd});
`ifdef MEM_BUS_ARBITER_PERF_EN
        check("idle:perf_stall_delta", 64'(perf_stall_cnt - snap_stall), 64'h0);
`endif

        // Randomized steps over a small address window to force collisions.
        for (int n = 0; n < 60; n++) begin
            r.d_en   = 1'($urandom_range(0, 1));
            r.d_we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r.d_addr = 32'($urandom_range(0, 7)) << 2;
            r.d_wd   = $urandom;
            r.i_en   = 1'($urandom_range(0, 1));
            r.i_we   = ($urandom_range(0, 3) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r.i_addr = 32'($urandom_range(0, 7)) << 2;
            r.i_wd   = $urandom;
            model_txn(r, st);
            run_txn($sformatf("rand%0d", n), r, st, m_i_rd, m_d_rd);
        end

        @(negedge clk);
        drive(idle_req);
        @(negedge clk);
        check("mem_fields_zero_when_idle", 64'(zero_viol), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported, synchronous-read unified memory between the core's instruction-fetch port (ibus, the core's rom_* signals) and its data port (dbus, the core's ram_* signals).
- Serializes simultaneous requests and asserts stall to the core until every enabled request has completed.
- Returns read data from holding registers that stay stable while the core advances.
- Sits between Core and the memory model / SoC memory.

Parameters:
ADDR_WIDTH, 32, width of address buses
DATA_WIDTH, 32, width of data buses
SEL_WIDTH, 4, byte write-enable width (DATA_WIDTH/8)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
ibus_en  in  1  instruction request valid
ibus_write_en  in  SEL_WIDTH  instruction-port byte write enables (0 = read)
ibus_addr  in  ADDR_WIDTH  instruction address
ibus_write_data  in  DATA_WIDTH  instruction-port write data
ibus_read_data  out  DATA_WIDTH  registered instruction read data
dbus_en  in  1  data request valid
dbus_write_en  in  SEL_WIDTH  data byte write enables (0 = read)
dbus_addr  in  ADDR_WIDTH  data address
dbus_write_data  in  DATA_WIDTH  data write data
dbus_read_data  out  DATA_WIDTH  registered data read data
mem_en  out  1  memory access strobe
mem_write_en  out  SEL_WIDTH  memory byte write enables
mem_addr  out  ADDR_WIDTH  memory address
mem_write_data  out  DATA_WIDTH  memory write data
mem_read_data  in  DATA_WIDTH  memory read data, valid the cycle after issue
stall  out  1  core hold request

Behaviour:
- Core contract: ibus_*/dbus_* are held stable while stall=1. The core samples *_read_data and advances on the edge where stall=0.
- FSM states: IDLE, D_WAIT, I_WAIT, DONE (2-bit encoding).
- IDLE:
  - If dbus_en: issue dbus this cycle (mem_* = dbus_*), next state D_WAIT.
  - Else if ibus_en: issue ibus, next state I_WAIT.
  - Else: mem_en=0, stay in IDLE.
  - stall = ibus_en | dbus_en.
- D_WAIT:
  - Capture mem_read_data into dbus_read_data, but only if dbus_write_en==0.
  - If ibus_en: issue ibus this cycle, next state I_WAIT; else next state DONE.
  - stall=1.
- I_WAIT:
  - Capture mem_read_data into ibus_read_data if ibus_write_en==0.
  - mem_en=0, next state DONE, stall=1.
- DONE: mem_en=0, stall=0, next state IDLE unconditionally.
- Priority: dbus always first (it belongs to the older instruction); ibus is never starved because it is served in the same transaction.
- Latency (stall cycles):
  - single request: 2 stalled cycles (issue, capture) + DONE, i.e. 3 cycles per transaction;
  - both requests: 3 stalled cycles + DONE;
  - no request: 0.
- Writes take the same path as reads; the read-data holding register keeps its previous value.
- mem_* outputs are combinational from state and inputs. mem_write_en is forced to 0 and mem_addr/mem_write_data to 0 whenever mem_en=0.
- Read-data holding registers change only on capture and otherwise hold across any number of cycles.
- Reset (synchronous, any state, including mid-transaction):
  - next state IDLE;
  - ibus_read_data = dbus_read_data = 0;
  - stall=0 and mem_en=0 while rst=1.
  - A transaction interrupted by reset is dropped, not replayed.
- Request dropped by the core while stalled (contract violation): FSM completes the current state sequence anyway; the bench flags it.

Optional Feature:
- Macro: MEM_BUS_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with stall=1) and perf_conflict_cnt[31:0] (IDLE cycles with ibus_en & dbus_en).
  - Both counters clear on rst and wrap modulo 2^32.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Shared package/header: FSM state encodings (ARB_IDLE, ARB_D_WAIT, ARB_I_WAIT, ARB_DONE) and width macros reusing the bus definitions (address, data, mem-sel).
- One natural sub-module, mem_bus_arbiter_perf: the counter pair, instantiated only under the macro.
- FSM and mux stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with ibus_en=1 -> stall=0, mem_en=0, both read_data=0; release -> FSM enters IDLE and issues ibus_addr.
- Fetch only: ibus_en=1, addr=0x0000_0010, memory returns 0x2408_ABCD -> stall high 2 cycles, ibus_read_data=0x2408_ABCD in DONE, stall=0.
- Conflict: dbus read addr 0x100 (returns 0xABCD_0000) plus ibus addr 0x14 -> mem_addr sequence 0x100, 0x14; stall high 3 cycles; both buffers correct; perf_conflict_cnt=1 when MEM_BUS_ARBITER_PERF_EN is defined.
- Data write: dbus_write_en=4'b0011, data 0x1234_5678, addr 0x200 -> one mem_en pulse with sel 0011; dbus_read_data unchanged from prior value.
- Reset mid-operation: assert rst in D_WAIT -> next cycle IDLE, no I_WAIT issue, buffers 0.
- Idle: both enables low for 10 cycles -> stall=0, mem_en=0 throughout; perf_stall_cnt does not increment.
